// File: rtl/v_store_sequencer_if.sv
// Command, status and memory-lane signals of the vector store sequencer.
// The vmask signal exists only when V_STORE_MASK_EN is defined.
interface v_store_sequencer_if #(
    parameter int NBANKS   = 4,
    parameter int VLEN     = 128,
    parameter int BANK_W   = 32,
    parameter int ADDR_W   = 14,
    parameter int STRIDE_W = 5
);
    logic                       start;
    logic [3:0]                 store_op;
    logic [2:0]                 lmul;
    logic [ADDR_W-1:0]          address;
    logic [STRIDE_W-1:0]        stride;
    logic [4*VLEN-1:0]          data;
`ifdef V_STORE_MASK_EN
    logic [4*VLEN/8-1:0]        vmask;
`endif
    logic                       mem_ready;
    logic                       busy;
    logic [NBANKS-1:0]          lane_we;
    logic [NBANKS*ADDR_W-1:0]   lane_addr;
    logic [NBANKS*BANK_W-1:0]   lane_data;
    logic [1:0]                 lane_size;
    logic                       done;
    logic                       err;

    modport master (
`ifdef V_STORE_MASK_EN
        output vmask,
`endif
        output start, store_op, lmul, address, stride, data, mem_ready,
        input  busy, lane_we, lane_addr, lane_data, lane_size, done, err
    );

    modport slave (
`ifdef V_STORE_MASK_EN
        input  vmask,
`endif
        input  start, store_op, lmul, address, stride, data, mem_ready,
        output busy, lane_we, lane_addr, lane_data, lane_size, done, err
    );
endinterface

// File: rtl/v_store_sequencer.sv
// Multi-lane vector store sequencer: unit-stride and strided stores over NBANKS lanes.
// Optional per-element write mask enabled by defining V_STORE_MASK_EN.
module v_store_sequencer #(
    parameter int NBANKS   = 4,
    parameter int VLEN     = 128,
    parameter int BANK_W   = 32,
    parameter int ADDR_W   = 14,
    parameter int STRIDE_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    v_store_sequencer_if.slave bus
);
    localparam int MAX_ELEM = 4 * VLEN / 8;
    localparam int CNT_W    = $clog2(MAX_ELEM + 1);
    localparam int BANK_SH  = $clog2(NBANKS);

    typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_t;

    state_t                        state;
    logic [CNT_W-1:0]              beat;
    logic [CNT_W-1:0]              last_beat;
    logic                          busy_q;
    logic                          done_q;
    logic                          err_q;
    logic [NBANKS-1:0]             we_q;
    logic [NBANKS-1:0][ADDR_W-1:0] addr_q;
    logic [NBANKS-1:0][BANK_W-1:0] data_q;
    logic [1:0]                    size_q;

    logic [1:0]                    cap_lmul;
    logic                          cap_strided;
    logic [ADDR_W-1:0]             cap_addr;
    logic [STRIDE_W-1:0]           cap_stride;
    logic [4*VLEN-1:0]             cap_data;
`ifdef V_STORE_MASK_EN
    logic [MAX_ELEM-1:0]           cap_mask;
    logic [MAX_ELEM-1:0]           src_mask;
`endif

    logic                          op_legal;
    logic                          op_strided;
    logic [1:0]                    op_size;
    logic                          cmd_legal;

    logic [1:0]                    src_size;
    logic [1:0]                    src_lmul;
    logic                          src_strided;
    logic [ADDR_W-1:0]             src_addr;
    logic [STRIDE_W-1:0]           src_stride;
    logic [4*VLEN-1:0]             src_data;
    logic [ADDR_W-1:0]             src_off;
    int                            src_beat;
    int                            src_nelem;
    int                            src_nbeats;
    int                            elem;
    logic [31:0]                   elem_word;

    logic [NBANKS-1:0]             nxt_we;
    logic [NBANKS-1:0][ADDR_W-1:0] nxt_addr;
    logic [NBANKS-1:0][BANK_W-1:0] nxt_data;

    // In IDLE the next beat is beat 0 of the incoming command, otherwise beat+1 of
    // the captured one, so a single lane generator feeds the registered outputs.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        op_legal    = 1'b1;
        op_strided  = 1'b0;
        op_size     = 2'd0;
        src_size    = size_q;
        src_lmul    = cap_lmul;
        src_strided = cap_strided;
        src_addr    = cap_addr;
        src_stride  = cap_stride;
        src_data    = cap_data;
        src_beat    = int'(beat) + 1;
`ifdef V_STORE_MASK_EN
        src_mask    = cap_mask;
`endif
        elem        = 0;
        elem_word   = '0;
        nxt_we      = '0;
        nxt_addr    = '0;
        nxt_data    = '0;

        case (bus.store_op)
            4'd7:    op_size = 2'd0;
            4'd8:    op_size = 2'd1;
            4'd9:    op_size = 2'd2;
            4'd10:   begin op_size = 2'd0; op_strided = 1'b1; end
            4'd11:   begin op_size = 2'd1; op_strided = 1'b1; end
            4'd12:   begin op_size = 2'd2; op_strided = 1'b1; end
            default: op_legal = 1'b0;
        endcase
        cmd_legal = op_legal && (bus.lmul <= 3'd2);

        if (state == IDLE) begin
            src_size    = op_size;
            src_lmul    = bus.lmul[1:0];
            src_strided = op_strided;
            src_addr    = bus.address;
            src_stride  = bus.stride;
            src_data    = bus.data;
            src_beat    = 0;
`ifdef V_STORE_MASK_EN
            src_mask    = bus.vmask;
`endif
        end

        src_nelem  = (VLEN << src_lmul) >> (3 + int'(src_size));
        src_nbeats = (src_nelem + NBANKS - 1) >> BANK_SH;
        src_off    = src_strided ? ADDR_W'(src_stride) : ADDR_W'(1 << src_size);

        for (int k = 0; k < NBANKS; k++) begin
            elem        = src_beat * NBANKS + k;
            elem_word   = 32'(src_data >> (elem << (3 + int'(src_size))));
            nxt_we[k]   = (elem < src_nelem);
`ifdef V_STORE_MASK_EN
            nxt_we[k]   = nxt_we[k] & 1'(src_mask >> elem);
`endif
            // Address arithmetic stays ADDR_W wide, so it wraps modulo 2^ADDR_W.
            nxt_addr[k] = src_addr + ADDR_W'(elem) * src_off;
            case (src_size)
                2'd0:    nxt_data[k] = BANK_W'(elem_word[7:0]);
                2'd1:    nxt_data[k] = BANK_W'(elem_word[15:0]);
                default: nxt_data[k] = BANK_W'(elem_word);
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            last_beat <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            we_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            size_q    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        size_q <= op_size;
                        beat   <= '0;
                        if (cmd_legal) begin
                            state     <= ISSUE;
                            last_beat <= CNT_W'(src_nbeats - 1);
                            we_q      <= nxt_we;
                            addr_q    <= nxt_addr;
                            data_q    <= nxt_data;
                        end else begin
                            state  <= FINISH;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        if (beat == last_beat) begin
                            state  <= FINISH;
                            we_q   <= '0;
                            done_q <= 1'b1;
                            err_q  <= 1'b0;
                        end else begin
                            beat   <= beat + CNT_W'(1);
                            we_q   <= nxt_we;
                            addr_q <= nxt_addr;
                            data_q <= nxt_data;
                        end
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the captured payload has no reset; it is only read during ISSUE,
    // which can only be entered after a fresh capture.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            cap_lmul    <= bus.lmul[1:0];
            cap_strided <= op_strided;
            cap_addr    <= bus.address;
            cap_stride  <= bus.stride;
            cap_data    <= bus.data;
`ifdef V_STORE_MASK_EN
            cap_mask    <= bus.vmask;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.lane_we   = we_q;
    assign bus.lane_addr = addr_q;
    assign bus.lane_data = data_q;
    assign bus.lane_size = size_q;
endmodule

// File: tb/tb_v_store_sequencer.sv
// Directed self-checking bench for v_store_sequencer (default configuration).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_v_store_sequencer;
    localparam int NBANKS   = 4;
    localparam int VLEN     = 128;
    localparam int BANK_W   = 32;
    localparam int ADDR_W   = 14;
    localparam int STRIDE_W = 5;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    v_store_sequencer_if #(
        .NBANKS(NBANKS), .VLEN(VLEN), .BANK_W(BANK_W), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)
    ) bus ();

    v_store_sequencer #(
        .NBANKS(NBANKS), .VLEN(VLEN), .BANK_W(BANK_W), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Present a command for one edge; returns at the falling edge of cycle T+1.
    task automatic send(input logic [3:0] op, input logic [2:0] lm,
                        input logic [ADDR_W-1:0] a, input logic [STRIDE_W-1:0] s);
        bus.store_op = op;
        bus.lmul     = lm;
        bus.address  = a;
        bus.stride   = s;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.store_op  = '0;
        bus.lmul      = '0;
        bus.address   = '0;
        bus.stride    = '0;
        bus.data      = '0;
        bus.mem_ready = 1'b1;
`ifdef V_STORE_MASK_EN
        bus.vmask     = '1;
`endif
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin $display("FAIL rst_busy got=%b want=0", bus.busy); errors++; end
        checks++; if (bus.lane_we !== 4'h0) begin $display("FAIL rst_we got=%h want=0", bus.lane_we); errors++; end
        checks++; if (bus.lane_addr !== '0 || bus.lane_data !== '0) begin
            $display("FAIL rst_addr_data got=%h/%h want=0/0", bus.lane_addr, bus.lane_data); errors++; end
        checks++; if ({bus.lane_size, bus.done, bus.err} !== 4'b0) begin
            $display("FAIL rst_size_done_err got=%b want=0000", {bus.lane_size, bus.done, bus.err}); errors++; end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unit_stride();
        bus.data = '0;
        for (int k = 0; k < 4; k++) bus.data[k*32 +: 32] = 32'(k) * 32'h11111111;
        send(4'd9, 3'd0, 14'h0, 5'd0);
        checks++; if (bus.busy !== 1'b1) begin $display("FAIL us_busy got=%b want=1", bus.busy); errors++; end
        checks++; if (bus.lane_we !== 4'hF) begin $display("FAIL us_we got=%h want=f", bus.lane_we); errors++; end
        checks++; if (bus.lane_addr !== {14'd12, 14'd8, 14'd4, 14'd0}) begin
            $display("FAIL us_addr got=%h want=%h", bus.lane_addr, {14'd12, 14'd8, 14'd4, 14'd0}); errors++; end
        checks++; if (bus.lane_data !== {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000}) begin
            $display("FAIL us_data got=%h", bus.lane_data); errors++; end
        checks++; if (bus.lane_size !== 2'd2 || bus.done !== 1'b0) begin
            $display("FAIL us_size_done got=%0d/%b want=2/0", bus.lane_size, bus.done); errors++; end
        @(negedge clk);
        checks++; if ({bus.done, bus.err, bus.busy, bus.lane_we} !== {3'b101, 4'h0}) begin
            $display("FAIL us_done got=%b want=1010000", {bus.done, bus.err, bus.busy, bus.lane_we}); errors++; end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL us_idle got=%b%b want=00", bus.busy, bus.done); errors++; end
    endtask

    // Four beats; start and changed inputs during the command must be ignored.
    task automatic test_lmul4();
        logic [NBANKS*ADDR_W-1:0] exp_addr;
        logic [NBANKS*BANK_W-1:0] exp_data;
        for (int j = 0; j < 16; j++) bus.data[j*32 +: 32] = 32'(j) * 32'h11111111;
        send(4'd9, 3'd2, 14'h100, 5'd0);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                exp_addr[k*ADDR_W +: ADDR_W] = 14'h100 + 14'(4 * (4*b + k));
                exp_data[k*BANK_W +: BANK_W] = 32'(4*b + k) * 32'h11111111;
            end
            checks++; if (bus.lane_we !== 4'hF || bus.lane_addr !== exp_addr) begin
                $display("FAIL l4_addr beat=%0d got=%h/%h want=f/%h", b, bus.lane_we, bus.lane_addr, exp_addr); errors++; end
            checks++; if (bus.lane_data !== exp_data) begin
                $display("FAIL l4_data beat=%0d got=%h want=%h", b, bus.lane_data, exp_data); errors++; end
            if (b == 3) begin
                checks++; if (bus.lane_addr[3*ADDR_W +: ADDR_W] !== 14'h13C || bus.lane_data[127:96] !== 32'hffffffff) begin
                    $display("FAIL l4_last got=%h/%h want=13c/ffffffff",
                             bus.lane_addr[3*ADDR_W +: ADDR_W], bus.lane_data[127:96]); errors++; end
            end
            if (b == 0) begin
                bus.data    = '1;
                bus.address = 14'h2000;
                bus.start   = 1'b1;
            end
            if (b == 2) bus.start = 1'b0;
            @(negedge clk);
        end
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
            $display("FAIL l4_done got=%b/%b want=1/1", bus.done, bus.busy); errors++; end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin $display("FAIL l4_idle got=%b want=0", bus.busy); errors++; end
    endtask

    task automatic test_strided_wrap();
        bus.data = '0;
        for (int i = 0; i < 8; i++) bus.data[i*16 +: 16] = 16'hA000 + 16'(i);
        send(4'd11, 3'd0, 14'h3FF8, 5'd6);
        checks++; if (bus.lane_addr !== {14'h000A, 14'h0004, 14'h3FFE, 14'h3FF8}) begin
            $display("FAIL sw_addr0 got=%h", bus.lane_addr); errors++; end
        checks++; if (bus.lane_data !== {32'hA003, 32'hA002, 32'hA001, 32'hA000} || bus.lane_size !== 2'd1) begin
            $display("FAIL sw_data0 got=%h size=%0d", bus.lane_data, bus.lane_size); errors++; end
        @(negedge clk);
        checks++; if (bus.lane_we !== 4'hF || bus.lane_addr !== {14'h0022, 14'h001C, 14'h0016, 14'h0010}) begin
            $display("FAIL sw_addr1 got=%h/%h", bus.lane_we, bus.lane_addr); errors++; end
        checks++; if (bus.lane_data !== {32'hA007, 32'hA006, 32'hA005, 32'hA004}) begin
            $display("FAIL sw_data1 got=%h", bus.lane_data); errors++; end
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin $display("FAIL sw_done got=%b want=1", bus.done); errors++; end
        @(negedge clk);
    endtask

    // Beat 1 stalled for three cycles; done must land in cycle T+12.
    task automatic test_stall();
        int                       eb;
        logic [NBANKS*ADDR_W-1:0] exp_addr;
        logic [NBANKS*BANK_W-1:0] exp_data;
        bus.data = '0;
        for (int i = 0; i < 32; i++) bus.data[i*8 +: 8] = 8'(i);
        send(4'd7, 3'd1, 14'h20, 5'd0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc <= 11) begin
                eb = (cyc == 1) ? 0 : (cyc <= 5) ? 1 : cyc - 4;
                for (int k = 0; k < 4; k++) begin
                    exp_addr[k*ADDR_W +: ADDR_W] = 14'h20 + 14'(4*eb + k);
                    exp_data[k*BANK_W +: BANK_W] = 32'(4*eb + k);
                end
                checks++; if ({bus.lane_we, bus.done} !== 5'b11110 || bus.lane_addr !== exp_addr) begin
                    $display("FAIL st_addr cyc=%0d got=%h/%b/%h want=f/0/%h", cyc, bus.lane_we, bus.done, bus.lane_addr, exp_addr); errors++; end
                checks++; if (bus.lane_data !== exp_data || bus.lane_size !== 2'd0) begin
                    $display("FAIL st_data cyc=%0d got=%h/%0d want=%h/0", cyc, bus.lane_data, bus.lane_size, exp_data); errors++; end
            end else begin
                checks++; if (bus.done !== 1'b1 || bus.lane_we !== 4'h0) begin
                    $display("FAIL st_done got=%b/%h want=1/0", bus.done, bus.lane_we); errors++; end
            end
            bus.mem_ready = !(cyc >= 2 && cyc <= 4);
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_illegal();
        send(4'd3, 3'd0, 14'h0, 5'd0);
        checks++; if ({bus.done, bus.err, bus.busy, bus.lane_we} !== {3'b111, 4'h0}) begin
            $display("FAIL il_op got=%b want=1110000", {bus.done, bus.err, bus.busy, bus.lane_we}); errors++; end
        bus.store_op = 4'd9;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if ({bus.busy, bus.done, bus.lane_we} !== 6'b0) begin
            $display("FAIL il_after got=%b want=000000", {bus.busy, bus.done, bus.lane_we}); errors++; end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.lane_we !== 4'h0) begin
            $display("FAIL il_ignored got=%b/%h want=0/0", bus.busy, bus.lane_we); errors++; end
        send(4'd9, 3'd5, 14'h0, 5'd0);
        checks++; if ({bus.done, bus.err, bus.lane_we} !== {2'b11, 4'h0}) begin
            $display("FAIL il_lmul got=%b want=110000", {bus.done, bus.err, bus.lane_we}); errors++; end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
            $display("FAIL il_lmul_end got=%b%b want=00", bus.done, bus.err); errors++; end
    endtask

    task automatic test_reset_mid();
        send(4'd9, 3'd2, 14'h0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({bus.busy, bus.done, bus.lane_we} !== 6'b0) begin
            $display("FAIL rm_reset got=%b want=000000", {bus.busy, bus.done, bus.lane_we}); errors++; end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL rm_nodone got=%b/%b want=0/0", bus.done, bus.busy); errors++; end
        bus.data = '0;
        for (int k = 0; k < 4; k++) bus.data[k*32 +: 32] = 32'hC0DE0000 + 32'(k);
        send(4'd9, 3'd0, 14'h40, 5'd0);
        checks++; if (bus.lane_we !== 4'hF || bus.lane_addr !== {14'h4C, 14'h48, 14'h44, 14'h40}) begin
            $display("FAIL rm_new_addr got=%h/%h", bus.lane_we, bus.lane_addr); errors++; end
        checks++; if (bus.lane_data !== {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000}) begin
            $display("FAIL rm_new_data got=%h", bus.lane_data); errors++; end
        @(negedge clk);
        checks++; if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
            $display("FAIL rm_new_done got=%b/%b want=1/0", bus.done, bus.err); errors++; end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unit_stride();
        test_lmul4();
        test_strided_wrap();
        test_stall();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/v_store_sequencer.md
# v_store_sequencer

Parametrised multi-lane vector store sequencer for the vector coprocessor LSU. It accepts one store command carrying a register group of up to four VLEN-bit registers (LMUL 1/2/4), a base byte address and an optional byte stride. It then issues element writes to NBANKS memory lanes over successive beats, honouring memory back-pressure and signalling completion. It supersedes the fixed four-lane, unit-stride-only store unit and adds strided addressing, variable lane count, a start/busy handshake and stall support.

## Interface
Parameters:
- NBANKS, 4, number of memory lanes written per beat (power of two, 1..8)
- VLEN, 128, bits per vector register
- BANK_W, 32, lane data width (≥32)
- ADDR_W, 14, byte address width (equals DATAMEM_BITS)
- STRIDE_W, 5, stride field width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  command request; accepted only when busy=0
- store_op  in  4  7 vse8, 8 vse16, 9 vse32, 10 vsse8, 11 vsse16, 12 vsse32
- lmul  in  3  0→1, 1→2, 2→4 registers; others illegal
- address  in  ADDR_W  base byte address
- stride  in  STRIDE_W  byte stride, strided ops only
- data  in  4*VLEN  register group, element i at data[i*EEW +: EEW]
- mem_ready  in  1  memory accepts current beat
- busy  out  1  command in progress
- lane_we  out  NBANKS  per-lane write enable
- lane_addr  out  NBANKS*ADDR_W  per-lane byte address
- lane_data  out  NBANKS*BANK_W  per-lane element, zero-extended
- lane_size  out  2  0 byte, 1 half, 2 word
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = command rejected

## Operation
- States: IDLE, ISSUE, FINISH.
- IDLE: busy=0. On start=1, capture store_op, lmul, address, stride and data.
  - Legal command → ISSUE.
  - Illegal store_op (not 7..12) or lmul (>2) → FINISH with err latched to 1.
- EEW = 8/16/32 from store_op. NELEM = VLEN*LMUL/EEW. NBEATS = ceil(NELEM/NBANKS).
- ISSUE, beat b: lane k carries element i = b*NBANKS+k.
  - lane_we[k]=1 iff i<NELEM.
  - Byte offset per element: unit-stride = EEW/8; strided = stride (stride=0 allowed: every element goes to the base address).
  - lane_addr = address + i*offset, modulo 2^ADDR_W (wraps silently).
- A beat retires in a cycle where mem_ready=1. The beat counter then advances.
- After the last beat retires → FINISH.
- FINISH: done=1 for exactly one cycle, err as latched, then → IDLE.
- start while busy=1 is ignored. Captured data is not affected by input changes after acceptance.
- Reset: the FSM and counters are cleared on any cycle with rst=1, including mid-command. The partially issued command is abandoned.

## Timing
- Reset values: busy=0, lane_we=0, lane_addr=0, lane_data=0, lane_size=0, done=0, err=0.
- start accepted at edge T → busy=1 and beat 0 outputs valid from T+1.
- Each beat is held stable while mem_ready=0. Minimum one cycle per beat.
- Last beat retires at edge E → done=1 during cycle E+1, busy=1 through that cycle, busy=0 at E+2.
- Illegal command: done=err=1 in cycle T+1, no lane_we asserted.
- Unstalled latency from start to done = NBEATS+1 cycles. Back-to-back start is allowed in the cycle after done.
- lane_we is 0 in every cycle outside ISSUE.

## Configuration
- V_STORE_MASK_EN defined:
  - Adds input vmask [4*VLEN/8-1:0], captured with the command.
  - lane_we[k] additionally requires vmask[i]=1.
  - A beat whose lanes are all masked off still takes one cycle (beat count unchanged).
- Undefined: no vmask port; all elements below NELEM are written.

## Test plan
- vse32, lmul=0, address=0, data words 0x00000000..0x33333333 → 1 beat; lanes 0..3 at addresses 0,4,8,12 with data 0x00000000, 0x11111111, 0x22222222, 0x33333333; done at T+2.
- vse32, lmul=2, address=0x100, 16-word pattern 0x00000000..0xffffffff → 4 beats; beat 3 lane 3 at address 0x13C with data 0xffffffff; done on cycle 5.
- vsse16, lmul=0, address=0x3FF8, stride=6 → 8 elements over 2 beats; element 2 at address 0x3FF8+12 wrapped to 0x0004; lane_size=1.
- vse8, lmul=1, mem_ready=0 for 3 cycles during beat 1 → beat 1 outputs held constant; 8 beats total; done at T+12.
- store_op=3 (or lmul=5) → done=err=1 at T+1, lane_we=0 throughout; a second start during busy is ignored.
- rst=1 during beat 2 of a 4-beat store → next cycle busy=0, lane_we=0, no done; a new command then completes normally.
